seven_seg_pwm_scan: RTL

- Downstream consumer of the stopwatch digit outputs: sec_0, sec_1, min_0, min_1, hr_0, hr_1.
- Time-multiplexes the six BCD digits onto a common-anode 6-digit 7-segment display.
- PWM-dims the lit anode for brightness control, with a blanking guard between digits to prevent ghosting.
- Sits between the stopwatch core and the board pins.

---
 rtl/seven_seg_pkg.sv | 53 +++++
 rtl/bcd_to_7seg.sv | 26 ++
 rtl/seven_seg_pwm_scan.sv | 112 +++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the six-digit 7-segment scan driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seven_seg_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned DIGIT_W    = 4;

  typedef logic [2:0] digit_idx_t;
  typedef logic [6:0] seg_t;

  localparam digit_idx_t LAST_IDX = 3'(NUM_DIGITS - 1);

  localparam seg_t SEG_0     = 7'h40;
  localparam seg_t SEG_1     = 7'h79;
  localparam seg_t SEG_2     = 7'h24;
  localparam seg_t SEG_3     = 7'h30;
  localparam seg_t SEG_4     = 7'h19;
  localparam seg_t SEG_5     = 7'h12;
  localparam seg_t SEG_6     = 7'h02;
  localparam seg_t SEG_7     = 7'h78;
  localparam seg_t SEG_8     = 7'h00;
  localparam seg_t SEG_9     = 7'h10;
  localparam seg_t SEG_BLANK = 7'h7F;

  // Decimal points sit after hours and minutes (hh.mm.ss)
  localparam logic [NUM_DIGITS-1:0] DP_MASK = 6'b010100;

  // One consistent snapshot of the stopwatch time
  typedef struct packed {
    logic [0:0] hr_1;
    logic [3:0] hr_0;
    logic [2:0] min_1;
    logic [3:0] min_0;
    logic [2:0] sec_1;
    logic [3:0] sec_0;
  } time_digits_t;

  function automatic logic [DIGIT_W-1:0] digit_sel(time_digits_t t, digit_idx_t idx);
    logic [DIGIT_W-1:0] d;
    d = '0;
    case (idx)
      3'd0:    d = t.sec_0;
      3'd1:    d = DIGIT_W'(t.sec_1);
      3'd2:    d = t.min_0;
      3'd3:    d = DIGIT_W'(t.min_1);
      3'd4:    d = t.hr_0;
      3'd5:    d = DIGIT_W'(t.hr_1);
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder; codes 10-15 decode to blank.
module bcd_to_7seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (bcd)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_pwm_scan.sv
// Multiplexes six stopwatch digits onto a common-anode display with PWM dimming
// and a blanking guard per slot. Optional macro SEVEN_SEG_LEAD_ZERO_BLANK_EN hides leading hour zeros.
module seven_seg_pwm_scan
  import seven_seg_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 200_000,
  parameter int unsigned BLANK_CYCLES   = 64,
  parameter int unsigned PWM_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       sec_0,
  input  logic [2:0]       sec_1,
  input  logic [3:0]       min_0,
  input  logic [2:0]       min_1,
  input  logic [3:0]       hr_0,
  input  logic             hr_1,
  input  logic [PWM_W-1:0] duty,
  output logic [5:0]       an,
  output logic [6:0]       seg,
  output logic             dp
);

  localparam int unsigned SLOT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  logic [SLOT_W-1:0]     slot_cnt;
  logic [PWM_W-1:0]      pwm_cnt;
  logic [PWM_W-1:0]      duty_lat;
  digit_idx_t            idx;
  time_digits_t          snap;

  logic                  slot_start_c;
  logic                  slot_wrap_c;
  logic                  pwm_on_c;
  logic                  lead_blank_c;
  logic [DIGIT_W-1:0]    digit_c;
  logic [6:0]            dec_seg_c;
  logic [6:0]            seg_c;
  logic [NUM_DIGITS-1:0] an_c;
  logic                  dp_c;

  assign slot_start_c = (slot_cnt == '0);
  assign slot_wrap_c  = (slot_cnt == SLOT_W'(REFRESH_CYCLES - 1));
  assign digit_c      = digit_sel(snap, idx);

  // Slot timer, digit index and per-slot PWM counter
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      pwm_cnt  <= '0;
      idx      <= '0;
    end else if (slot_wrap_c) begin
      slot_cnt <= '0;
      pwm_cnt  <= '0;
      idx      <= (idx == LAST_IDX) ? '0 : idx + 3'd1;
    end else begin
      slot_cnt <= slot_cnt + SLOT_W'(1);
      pwm_cnt  <= pwm_cnt + PWM_W'(1);
    end
  end

  // Brightness is latched per slot; the time is latched once per scan so it never tears
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_lat <= '0;
      snap     <= '0;
    end else if (slot_start_c) begin
      duty_lat <= duty;
      if (idx == '0) begin
        snap <= {hr_1, hr_0, min_1, min_0, sec_1, sec_0};
      end
    end
  end

  bcd_to_7seg u_dec (
    .bcd   (digit_c),
    .seg_c (dec_seg_c)
  );

  always_comb begin
    pwm_on_c     = (slot_cnt >= SLOT_W'(BLANK_CYCLES)) && (pwm_cnt < duty_lat);
    lead_blank_c = 1'b0;
`ifdef SEVEN_SEG_LEAD_ZERO_BLANK_EN
    if ((idx == 3'd5) && (snap.hr_1 == 1'b0)) begin
      lead_blank_c = 1'b1;
    end
    if ((idx == 3'd4) && (snap.hr_1 == 1'b0) && (snap.hr_0 == 4'd0)) begin
      lead_blank_c = 1'b1;
    end
`endif
    an_c = '1;
    if (pwm_on_c && !lead_blank_c) begin
      an_c[idx] = 1'b0;
    end
    seg_c = lead_blank_c ? SEG_BLANK : dec_seg_c;
    dp_c  = !(pwm_on_c && DP_MASK[idx]);
  end

  // Registered pin drivers
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_c;
      seg <= seg_c;
      dp  <= dp_c;
    end
  end

endmodule
